// File: rtl/switch_event_pkg.sv
// Shared types and helpers for the switch event arbiter.
package switch_event_pkg;

    localparam int MAX_NUM_SW = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin search: first set request at or above start, wrapping at N-1.
module round_robin_picker #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         any,
    output logic [W-1:0] sel
);

    int pos;

    // Scanning offsets from the far end down lets the nearest request win last.
    always_comb begin
        any = 1'b0;
        sel = '0;
        pos = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(start) + k;
            if (pos >= N) pos = pos - N;
            if (req[pos]) begin
                any = 1'b1;
                sel = W'(pos);
            end
        end
    end

endmodule

// File: rtl/switch_event_arbiter.sv
// Queues one pending event per switch and hands them out round-robin over valid/ready.
// Define SWITCH_EVENT_RELEASE_EN to also report releases (adds o_Event_Press).
module switch_event_arbiter
    import switch_event_pkg::*;
#(
    parameter  int NUM_SW = 4,
    localparam int IDX_W  = clog2_min1(NUM_SW)
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [NUM_SW-1:0] i_Switch,
    input  logic              i_Event_Ready,
    output logic              o_Event_Valid,
    output logic [IDX_W-1:0]  o_Event_Idx,
`ifdef SWITCH_EVENT_RELEASE_EN
    output logic              o_Event_Press,
`endif
    output logic [NUM_SW-1:0] o_Overrun,
    input  logic              i_Clear_Overrun,
    output logic              o_Fsm_State
);

    // Handshake: an event transfers on a rising edge where o_Event_Valid & i_Event_Ready.
    // Once raised, o_Event_Valid and o_Event_Idx hold until that transfer happens.
`ifdef SWITCH_EVENT_RELEASE_EN
    localparam int SLOTS = 2 * NUM_SW;
`else
    localparam int SLOTS = NUM_SW;
`endif
    localparam int SLOT_W = clog2_min1(SLOTS);

    state_t              state, state_next;
    logic                init;
    logic [NUM_SW-1:0]   sw_prev;
    logic [NUM_SW-1:0]   rise;
    logic [NUM_SW-1:0]   ov_set;
    logic [SLOTS-1:0]    pend, pend_next, set_req, clear_mask, lost;
    logic [SLOT_W-1:0]   ptr, cur_slot, next_slot, search_start, sel;
    logic                any, grant, handshake;

    assign rise = init ? '0 : (i_Switch & ~sw_prev);

`ifdef SWITCH_EVENT_RELEASE_EN
    logic [NUM_SW-1:0] fall;
    assign fall = init ? '0 : (~i_Switch & sw_prev);

    // Slot 2i is the press of switch i, slot 2i+1 its release.
    always_comb begin
        set_req = '0;
        ov_set  = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            set_req[2*i]   = rise[i];
            set_req[2*i+1] = fall[i];
            ov_set[i]      = lost[2*i] | lost[2*i+1];
        end
    end

    assign o_Event_Idx   = IDX_W'(cur_slot >> 1);
    assign o_Event_Press = ~cur_slot[0];
`else
    assign set_req     = rise;
    assign ov_set      = lost;
    assign o_Event_Idx = cur_slot;
`endif

    assign next_slot    = (cur_slot == SLOT_W'(SLOTS - 1)) ? '0 : cur_slot + SLOT_W'(1);
    // While offering, a grant only happens on a handshake, so search from the slot after the current one.
    assign search_start = (state == OFFER) ? next_slot : ptr;

    round_robin_picker #(
        .N(SLOTS),
        .W(SLOT_W)
    ) u_picker (
        .req  (pend),
        .start(search_start),
        .any  (any),
        .sel  (sel)
    );

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    grant      = 1'b1;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (i_Event_Ready) begin
                    handshake = 1'b1;
                    if (any) grant = 1'b1;
                    else state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        clear_mask = '0;
        if (grant) clear_mask[sel] = 1'b1;
    end

    // A new request landing on a slot being granted is a fresh event, not a lost one.
    assign pend_next = (pend & ~clear_mask) | set_req;
    assign lost      = set_req & pend & ~clear_mask;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            init      <= 1'b1;
            sw_prev   <= '0;
            pend      <= '0;
            ptr       <= '0;
            cur_slot  <= '0;
            o_Overrun <= '0;
        end else begin
            init      <= 1'b0;
            sw_prev   <= i_Switch;
            pend      <= pend_next;
            o_Overrun <= (i_Clear_Overrun ? '0 : o_Overrun) | ov_set;
            if (handshake) ptr <= next_slot;
            if (grant) cur_slot <= sel;
        end
    end

    assign o_Event_Valid = (state == OFFER);
    assign o_Fsm_State   = state;

endmodule
